// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU/LSU/MDU result sources in, register-file write port out.
// slave is the arbiter side, master is the producer/register-file side.
interface wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          alu_we_i;
  logic [AW-1:0] alu_waddr_i;
  logic [DW-1:0] alu_wdata_i;
  logic          alu_stall_o;
  logic          lsu_valid_i;
  logic          lsu_ready_o;
  logic [AW-1:0] lsu_waddr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          mdu_valid_i;
  logic          mdu_ready_o;
  logic [AW-1:0] mdu_waddr_i;
  logic [DW-1:0] mdu_wdata_i;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;

  modport slave (
    input  alu_we_i, alu_waddr_i, alu_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  mdu_valid_i, mdu_waddr_i, mdu_wdata_i,
    output alu_stall_o, lsu_ready_o, mdu_ready_o,
    output we_o, waddr_o, wdata_o
  );

  modport master (
    output alu_we_i, alu_waddr_i, alu_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output mdu_valid_i, mdu_waddr_i, mdu_wdata_i,
    input  alu_stall_o, lsu_ready_o, mdu_ready_o,
    input  we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU, LSU and MDU results onto the GPR write port; ALU 1 cycle, LSU/MDU >=2 cycles.
// Backpressure: LSU/MDU ready = own buffer empty; ALU never stalled unless built with WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  if (STARVE_LIM < 1) begin : g_lim_check
    $error("wb_arbiter: STARVE_LIM must be at least 1");
  end

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;

  logic          lsu_full;
  logic [AW-1:0] lsu_waddr;
  logic [DW-1:0] lsu_wdata;
  logic          mdu_full;
  logic [AW-1:0] mdu_waddr;
  logic [DW-1:0] mdu_wdata;
  logic          rr;

  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  logic          alu_cand;
  logic          buf_preempt;
  logic          lsu_elig;
  logic          mdu_elig;
  logic          rr_used;
  src_e          grant;

  assign alu_cand = bus.alu_we_i && (bus.alu_waddr_i != '0);

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] lsu_cnt;
  logic [CW-1:0] mdu_cnt;
  logic          lsu_hot;
  logic          mdu_hot;

  assign lsu_hot = lsu_full && (lsu_cnt == CW'(STARVE_LIM));
  assign mdu_hot = mdu_full && (mdu_cnt == CW'(STARVE_LIM));

  // When a starved buffer preempts the ALU, only starved buffers may take the slot.
  assign buf_preempt = alu_cand && (lsu_hot || mdu_hot);
  assign lsu_elig    = buf_preempt ? lsu_hot : lsu_full;
  assign mdu_elig    = buf_preempt ? mdu_hot : mdu_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_cnt <= '0;
      mdu_cnt <= '0;
    end else begin
      if (!lsu_full || grant == SRC_LSU) begin
        lsu_cnt <= '0;
      end else if (grant == SRC_ALU) begin
        lsu_cnt <= lsu_cnt + 1'b1;
      end
      if (!mdu_full || grant == SRC_MDU) begin
        mdu_cnt <= '0;
      end else if (grant == SRC_ALU) begin
        mdu_cnt <= mdu_cnt + 1'b1;
      end
    end
  end
`else
  assign buf_preempt = 1'b0;
  assign lsu_elig    = lsu_full;
  assign mdu_elig    = mdu_full;
`endif

  always_comb begin
    grant   = SRC_NONE;
    rr_used = 1'b0;
    if (alu_cand && !buf_preempt) begin
      grant = SRC_ALU;
    end else if (lsu_elig && mdu_elig) begin
      rr_used = 1'b1;
      grant   = rr ? SRC_MDU : SRC_LSU;
    end else if (lsu_elig) begin
      grant = SRC_LSU;
    end else if (mdu_elig) begin
      grant = SRC_MDU;
    end
  end

  // Drain only happens while full and capture only while empty, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_full  <= 1'b0;
      lsu_waddr <= '0;
      lsu_wdata <= '0;
      mdu_full  <= 1'b0;
      mdu_waddr <= '0;
      mdu_wdata <= '0;
      rr        <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      we_q <= (grant != SRC_NONE);
      case (grant)
        SRC_ALU: begin
          waddr_q <= bus.alu_waddr_i;
          wdata_q <= bus.alu_wdata_i;
        end
        SRC_LSU: begin
          waddr_q  <= lsu_waddr;
          wdata_q  <= lsu_wdata;
          lsu_full <= 1'b0;
        end
        SRC_MDU: begin
          waddr_q  <= mdu_waddr;
          wdata_q  <= mdu_wdata;
          mdu_full <= 1'b0;
        end
        default: ;
      endcase

      if (rr_used) begin
        rr <= (grant == SRC_LSU);
      end

      // Writes to x0 are accepted for handshake purposes and discarded.
      if (bus.lsu_valid_i && !lsu_full && (bus.lsu_waddr_i != '0)) begin
        lsu_full  <= 1'b1;
        lsu_waddr <= bus.lsu_waddr_i;
        lsu_wdata <= bus.lsu_wdata_i;
      end
      if (bus.mdu_valid_i && !mdu_full && (bus.mdu_waddr_i != '0)) begin
        mdu_full  <= 1'b1;
        mdu_waddr <= bus.mdu_waddr_i;
        mdu_wdata <= bus.mdu_wdata_i;
      end
    end
  end

  assign bus.lsu_ready_o = ~lsu_full;
  assign bus.mdu_ready_o = ~mdu_full;
  assign bus.alu_stall_o = buf_preempt;
  assign bus.we_o        = we_q;
  assign bus.waddr_o     = waddr_q;
  assign bus.wdata_o     = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: expected register-file writes queued at stimulus time, popped on each we_o.
// Builds with or without WB_STARVE_GUARD_EN; the ALU-stream section checks whichever behaviour is built.
module tb_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  logic [AW+DW-1:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW+DW-1:0] wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {a, d};
  endfunction

  // Every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && bus.we_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_write", 64'(sb_q.size()), 64'd1);
      end else begin
        logic [AW+DW-1:0] exp_w;
        exp_w = sb_q.pop_front();
        check_eq("wb_write", 64'({bus.waddr_o, bus.wdata_o}), 64'(exp_w));
      end
    end
  end

  initial begin
    int ia;
    logic exp_stall;
    logic exp_lrdy;

    bus.alu_we_i    = 1'b0;
    bus.alu_waddr_i = '0;
    bus.alu_wdata_i = '0;
    bus.lsu_valid_i = 1'b0;
    bus.lsu_waddr_i = '0;
    bus.lsu_wdata_i = '0;
    bus.mdu_valid_i = 1'b0;
    bus.mdu_waddr_i = '0;
    bus.mdu_wdata_i = '0;

    #2;
    check_eq("rst_we",     64'(bus.we_o), 64'd0);
    check_eq("rst_waddr",  64'(bus.waddr_o), 64'd0);
    check_eq("rst_wdata",  64'(bus.wdata_o), 64'd0);
    check_eq("rst_lrdy",   64'(bus.lsu_ready_o), 64'd1);
    check_eq("rst_mrdy",   64'(bus.mdu_ready_o), 64'd1);
    check_eq("rst_stall",  64'(bus.alu_stall_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single ALU result: written one cycle later, then we_o drops.
    bus.alu_we_i    = 1'b1;
    bus.alu_waddr_i = 5'd5;
    bus.alu_wdata_i = 32'hDEADBEEF;
    sb_q.push_back(wr(5'd5, 32'hDEADBEEF));
    step();
    bus.alu_we_i = 1'b0;
    check_eq("t1_we", 64'(bus.we_o), 64'd1);
    check_eq("t1_waddr", 64'(bus.waddr_o), 64'd5);
    step();
    check_eq("t1_we_off", 64'(bus.we_o), 64'd0);

    // LSU transfer: capture, then grant on the following edge.
    bus.lsu_valid_i = 1'b1;
    bus.lsu_waddr_i = 5'd3;
    bus.lsu_wdata_i = 32'h11;
    sb_q.push_back(wr(5'd3, 32'h11));
    step();
    bus.lsu_valid_i = 1'b0;
    check_eq("t2_lrdy_busy", 64'(bus.lsu_ready_o), 64'd0);
    check_eq("t2_we_early", 64'(bus.we_o), 64'd0);
    step();
    check_eq("t2_we", 64'(bus.we_o), 64'd1);
    check_eq("t2_waddr", 64'(bus.waddr_o), 64'd3);
    check_eq("t2_lrdy_back", 64'(bus.lsu_ready_o), 64'd1);
    step();

    // Both buffers full with rr=0: LSU first, then MDU.
    bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 5'd3; bus.lsu_wdata_i = 32'hA3;
    bus.mdu_valid_i = 1'b1; bus.mdu_waddr_i = 5'd4; bus.mdu_wdata_i = 32'hB4;
    sb_q.push_back(wr(5'd3, 32'hA3));
    sb_q.push_back(wr(5'd4, 32'hB4));
    step();
    bus.lsu_valid_i = 1'b0;
    bus.mdu_valid_i = 1'b0;
    check_eq("t3_lrdy", 64'(bus.lsu_ready_o), 64'd0);
    check_eq("t3_mrdy", 64'(bus.mdu_ready_o), 64'd0);
    step();
    check_eq("t3_first", 64'(bus.waddr_o), 64'd3);
    check_eq("t3_mrdy_hold", 64'(bus.mdu_ready_o), 64'd0);
    step();
    check_eq("t3_second", 64'(bus.waddr_o), 64'd4);
    check_eq("t3_we", 64'(bus.we_o), 64'd1);
    step();

    // rr now points at MDU, so a second collision writes MDU first.
    bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 5'd6; bus.lsu_wdata_i = 32'hC6;
    bus.mdu_valid_i = 1'b1; bus.mdu_waddr_i = 5'd7; bus.mdu_wdata_i = 32'hD7;
    sb_q.push_back(wr(5'd7, 32'hD7));
    sb_q.push_back(wr(5'd6, 32'hC6));
    step();
    bus.lsu_valid_i = 1'b0;
    bus.mdu_valid_i = 1'b0;
    step();
    check_eq("rr_mdu_first", 64'(bus.waddr_o), 64'd7);
    step();
    check_eq("rr_lsu_second", 64'(bus.waddr_o), 64'd6);
    step();

    // Continuous ALU stream against a full LSU buffer.
    bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 5'd9; bus.lsu_wdata_i = 32'h99;
    step();
    bus.lsu_valid_i = 1'b0;
    ia = 0;
    for (int c = 0; c < 8; c++) begin
      bus.alu_we_i    = 1'b1;
      bus.alu_waddr_i = AW'(10 + ia);
      bus.alu_wdata_i = 32'hA000_0000 + 32'(ia);
`ifdef WB_STARVE_GUARD_EN
      exp_stall = (c == 4);
      exp_lrdy  = (c > 4);
`else
      exp_stall = 1'b0;
      exp_lrdy  = 1'b0;
`endif
      #1;
      check_eq($sformatf("stream_stall_c%0d", c), 64'(bus.alu_stall_o), 64'(exp_stall));
      check_eq($sformatf("stream_lrdy_c%0d", c), 64'(bus.lsu_ready_o), 64'(exp_lrdy));
      if (exp_stall) begin
        sb_q.push_back(wr(5'd9, 32'h99));
      end else begin
        sb_q.push_back(wr(AW'(10 + ia), 32'hA000_0000 + 32'(ia)));
        ia++;
      end
      step();
    end
    bus.alu_we_i = 1'b0;
`ifndef WB_STARVE_GUARD_EN
    sb_q.push_back(wr(5'd9, 32'h99));
`endif
    repeat (3) step();
    check_eq("stream_drained_lrdy", 64'(bus.lsu_ready_o), 64'd1);

    // x0 load is dropped; reset with a full MDU buffer discards it.
    bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 5'd0; bus.lsu_wdata_i = 32'h55;
    step();
    bus.lsu_valid_i = 1'b0;
    check_eq("t6_drop_lrdy", 64'(bus.lsu_ready_o), 64'd1);
    bus.mdu_valid_i = 1'b1; bus.mdu_waddr_i = 5'd12; bus.mdu_wdata_i = 32'hCC;
    step();
    bus.mdu_valid_i = 1'b0;
    check_eq("t6_mrdy_full", 64'(bus.mdu_ready_o), 64'd0);
    check_eq("t6_drop_we", 64'(bus.we_o), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_async_we",    64'(bus.we_o), 64'd0);
    check_eq("t6_async_waddr", 64'(bus.waddr_o), 64'd0);
    check_eq("t6_async_wdata", 64'(bus.wdata_o), 64'd0);
    check_eq("t6_async_mrdy",  64'(bus.mdu_ready_o), 64'd1);
    check_eq("t6_async_lrdy",  64'(bus.lsu_ready_o), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) step();
    check_eq("t6_post_mrdy", 64'(bus.mdu_ready_o), 64'd1);
    check_eq("t6_post_we", 64'(bus.we_o), 64'd0);

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
